// File: rtl/ov7670_frame_emulator.sv
// OV7670-style camera transmitter: emits VSYNC/HREF framing and an RGB565 byte
// stream (high byte first) carrying one of four deterministic test patterns.
module ov7670_frame_emulator #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        pclk_in,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  p_data_out,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HW        = $clog2(LINE_LEN);
  localparam int unsigned ML_A      = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int unsigned ML_B      = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int unsigned MAX_LINES = (ML_A > ML_B) ? ML_A : ML_B;
  localparam int unsigned LW        = $clog2(MAX_LINES + 1);
  localparam int unsigned BAR_W     = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic [15:0]   fcount_q, fcount_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          fstart_q, fstart_d;
  logic          busy_q, busy_d;

  logic [LW-1:0] last_line;
  logic          line_end;
  logic          phase_end;
  logic          start;
  logic [9:0]    x;
  logic [5:0]    y_hi;
  logic [9:0]    bar;
  logic [15:0]   pixel;

  // Next-state sequencing; outputs are derived from the next position so they
  // line up with the state register on the same edge.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    pat_d     = pat_q;
    solid_d   = solid_q;
    fcount_d  = fcount_q;
    start     = 1'b0;
    last_line = '0;

    case (state_q)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBACK:  last_line = LW'(V_BACK - 1);
      ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      default:   last_line = LW'(V_FRONT - 1);
    endcase

    line_end  = (hcnt_q == H_LAST);
    phase_end = line_end && (lcnt_q == last_line);

    if (state_q == ST_IDLE) begin
      start = enable;
    end else begin
      if (line_end) begin
        hcnt_d = '0;
        lcnt_d = lcnt_q + LW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
      if (phase_end) begin
        lcnt_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          default: begin
            fcount_d = fcount_q + 16'd1;
            if (enable) start = 1'b1;
            else        state_d = ST_IDLE;
          end
        endcase
      end
    end

    // Pattern inputs are only sampled as a new frame begins.
    if (start) begin
      state_d = ST_VSYNC;
      hcnt_d  = '0;
      lcnt_d  = '0;
      pat_d   = pattern_sel;
      solid_d = solid_color;
    end

    x     = 10'(hcnt_d >> 1);
    y_hi  = 6'(lcnt_d >> 2);
    bar   = x / 10'(BAR_W);
    pixel = 16'h0000;
    case (pat_d)
      2'd0: begin
        if (bar < 10'd8) begin
          case (bar[2:0])
            3'd0:    pixel = 16'hFFFF;
            3'd1:    pixel = 16'hFFE0;
            3'd2:    pixel = 16'h07FF;
            3'd3:    pixel = 16'h07E0;
            3'd4:    pixel = 16'hF81F;
            3'd5:    pixel = 16'hF800;
            3'd6:    pixel = 16'h001F;
            default: pixel = 16'h0000;
          endcase
        end
      end
      2'd1:    pixel = solid_d;
      2'd2:    pixel = {x[8:4], y_hi, x[4:0]};
      default: pixel = (x[3] ^ y_hi[1]) ? 16'hFFFF : 16'h0000;
    endcase

    vsync_d  = (state_d == ST_VSYNC);
    href_d   = (state_d == ST_ACTIVE) && (hcnt_d < H_ACT_END);
    data_d   = href_d ? (hcnt_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    fstart_d = start;
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge pclk_in) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      pat_q    <= 2'd0;
      solid_q  <= 16'h0000;
      fcount_q <= 16'h0000;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= 8'h00;
      fstart_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      pat_q    <= pat_d;
      solid_q  <= solid_d;
      fcount_q <= fcount_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      data_q   <= data_d;
      fstart_q <= fstart_d;
      busy_q   <= busy_d;
    end
  end

  assign vsync_out   = vsync_q;
  assign href_out    = href_q;
  assign p_data_out  = data_q;
  assign frame_start = fstart_q;
  assign frame_count = fcount_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ov7670_frame_emulator.sv
// Bench for ov7670_frame_emulator with reduced frame geometry: timing table,
// directed corner sequences and randomized traffic against a frame-offset model.
`timescale 1ns/1ps
module tb_ov7670_frame_emulator;

  localparam int H_ACTIVE    = 8;
  localparam int V_ACTIVE    = 4;
  localparam int H_BLANK     = 4;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME       = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE_LEN;
  localparam int BAR_W       = H_ACTIVE / 8;
  localparam int NVEC        = 15;

  logic        pclk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        vsync_out, href_out, frame_start, busy;
  logic [7:0]  p_data_out;
  logic [15:0] frame_count;

  always #5 pclk_in = ~pclk_in;

  ov7670_frame_emulator #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .pclk_in(pclk_in), .reset(reset), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .vsync_out(vsync_out), .href_out(href_out), .p_data_out(p_data_out),
    .frame_start(frame_start), .frame_count(frame_count), .busy(busy)
  );

  typedef struct packed {
    int          cyc;
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        fs;
    logic [15:0] fc;
    logic        busy;
  } vec_t;

  vec_t       tbl [NVEC];
  logic [7:0] bars [16];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: frame in progress, offset within it, and the pattern latched at its start
  logic        m_act = 1'b0;
  int          m_off = 0;
  int          m_fc = 0;
  logic        m_start = 1'b0;
  logic [1:0]  m_pat = 2'd0;
  logic [15:0] m_solid = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_pix(input logic [1:0] p, input logic [15:0] s,
                                          input int x, input int y);
    logic [9:0] xv;
    logic [8:0] yv;
    xv = 10'(x);
    yv = 9'(y);
    case (p)
      2'd0: begin
        case (x / BAR_W)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: return s;
      2'd2: return {xv[8:4], yv[7:2], xv[4:0]};
      default: return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic step();
    int line, h, al;
    logic e_vs, e_hr, e_fs;
    logic [7:0] e_d;
    logic [15:0] pix;
    @(posedge pclk_in);
    cyc++;
    m_start = 1'b0;
    if (reset) begin
      m_act = 1'b0; m_off = 0; m_fc = 0;
    end else if (!m_act) begin
      if (enable) begin
        m_act = 1'b1; m_off = 0; m_pat = pattern_sel; m_solid = solid_color; m_start = 1'b1;
      end
    end else begin
      m_off++;
      if (m_off == FRAME) begin
        m_fc = (m_fc + 1) & 16'hFFFF;
        m_off = 0;
        if (enable) begin
          m_pat = pattern_sel; m_solid = solid_color; m_start = 1'b1;
        end else begin
          m_act = 1'b0;
        end
      end
    end
    #1;
    e_vs = 1'b0; e_hr = 1'b0; e_d = 8'h00; e_fs = 1'b0;
    if (m_act) begin
      line = m_off / LINE_LEN;
      h    = m_off % LINE_LEN;
      al   = line - VSYNC_LINES - V_BACK;
      e_vs = (line < VSYNC_LINES);
      e_fs = m_start;
      if (al >= 0 && al < V_ACTIVE && h < 2 * H_ACTIVE) begin
        e_hr = 1'b1;
        pix  = ref_pix(m_pat, m_solid, h / 2, al);
        e_d  = (h % 2 == 0) ? pix[15:8] : pix[7:0];
      end
    end
    chk("model", 32'({vsync_out, href_out, p_data_out, frame_start, frame_count, busy}),
        32'({e_vs, e_hr, e_d, e_fs, 16'(m_fc), m_act}));
  endtask

  // Expects reset asserted on the previous edge; enable rises in cycle 0.
  task automatic run_table();
    int k = 0;
    int rises = 0;
    int highs = 0;
    logic prev = 1'b0;
    reset = 1'b0; enable = 1'b1; pattern_sel = 2'd1; solid_color = 16'hABCD; cyc = 0;
    for (int c = 1; c <= 141; c++) begin
      step();
      if (c <= 140) begin
        if (href_out) highs++;
        if (href_out && !prev) rises++;
        prev = href_out;
      end
      if (k < NVEC && tbl[k].cyc == c) begin
        chk($sformatf("vec%0d_c%0d", k, c),
            32'({vsync_out, href_out, p_data_out, frame_start, frame_count, busy}),
            32'({tbl[k].vs, tbl[k].hr, tbl[k].d, tbl[k].fs, tbl[k].fc, tbl[k].busy}));
        k++;
      end
    end
    chk("href_pulses", 32'(rises), 32'(V_ACTIVE));
    chk("href_cycles", 32'(highs), 32'(V_ACTIVE * 2 * H_ACTIVE));
  endtask

  initial begin
    int idle_bad;
    //          cyc  vs    hr    data   fs    fc      busy
    tbl[0]  = '{1,   1'b1, 1'b0, 8'h00, 1'b1, 16'd0, 1'b1};
    tbl[1]  = '{2,   1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[2]  = '{20,  1'b1, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[3]  = '{21,  1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[4]  = '{40,  1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[5]  = '{41,  1'b0, 1'b1, 8'hAB, 1'b0, 16'd0, 1'b1};
    tbl[6]  = '{42,  1'b0, 1'b1, 8'hCD, 1'b0, 16'd0, 1'b1};
    tbl[7]  = '{56,  1'b0, 1'b1, 8'hCD, 1'b0, 16'd0, 1'b1};
    tbl[8]  = '{57,  1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[9]  = '{61,  1'b0, 1'b1, 8'hAB, 1'b0, 16'd0, 1'b1};
    tbl[10] = '{116, 1'b0, 1'b1, 8'hCD, 1'b0, 16'd0, 1'b1};
    tbl[11] = '{117, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[12] = '{121, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[13] = '{140, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 1'b1};
    tbl[14] = '{141, 1'b1, 1'b0, 8'h00, 1'b1, 16'd1, 1'b1};
    bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
             8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    repeat (3) step();
    chk("reset_state", 32'({vsync_out, href_out, p_data_out, frame_start, frame_count, busy}), 32'h0);

    // Frame timing with a solid pattern, then reset in the middle of an active line
    run_table();
    repeat (50) step();
    chk("mid_active", 32'({href_out, busy}), 32'b11);
    reset = 1'b1;
    step();
    chk("reset_mid_line", 32'({vsync_out, href_out, p_data_out, frame_start, frame_count, busy}), 32'h0);
    run_table();

    // Colour bars with one pixel per bar
    reset = 1'b1; enable = 1'b0; step();
    reset = 1'b0; enable = 1'b1; pattern_sel = 2'd0; cyc = 0;
    repeat (40) step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("bar_byte%0d", i), 32'({href_out, p_data_out}), 32'({1'b1, bars[i]}));
    end

    // Pattern change mid-frame waits for the next frame
    reset = 1'b1; step();
    reset = 1'b0; enable = 1'b1; pattern_sel = 2'd3; cyc = 0;
    repeat (45) step();
    pattern_sel = 2'd1; solid_color = 16'h1234;
    repeat (16) step();
    chk("checker_kept", 32'({href_out, p_data_out}), 32'({1'b1, 8'h00}));
    repeat (120) step();
    chk("solid_next_frame", 32'({href_out, p_data_out}), 32'({1'b1, 8'h12}));

    // Enable dropped inside frame 2: frame completes, then idle
    repeat (9) step();
    enable = 1'b0;
    repeat (90) step();
    chk("last_vfront", 32'({busy, frame_count}), 32'({1'b1, 16'd1}));
    step();
    chk("frame_done", 32'({busy, vsync_out, frame_count}), 32'({1'b0, 1'b0, 16'd2}));
    idle_bad = 0;
    repeat (40) begin
      step();
      if (vsync_out || busy || frame_start) idle_bad++;
    end
    chk("stays_idle", 32'(idle_bad), 32'd0);

    // Randomized enable / pattern / reset traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 29) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) solid_color = 16'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
